packet_xor_parity_accumulator: RTL



---
 rtl/xor_vec_using_mux.sv | 27 ++
 rtl/packet_xor_parity_accumulator.sv | 94 +++++++++
 2 files changed

// File: rtl/xor_vec_using_mux.sv
// Bitwise XOR built purely from 2:1 multiplexers and constants.
// mux2 is the only primitive; xor_vec_using_mux composes one XOR cell per bit from it.

module mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module xor_vec_using_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] b_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Inverter from constants: b ? 0 : 1.
        mux2 u_inv (.sel(b[i]), .d0(1'b1), .d1(1'b0), .y(b_n[i]));
        mux2 u_xor (.sel(a[i]), .d0(b[i]), .d1(b_n[i]), .y(y[i]));
    end
endmodule

// File: rtl/packet_xor_parity_accumulator.sv
// Streaming packet XOR accumulator: column XOR, parity, saturating word count and
// overflow, reported one cycle after the last beat of each packet.

module packet_xor_parity_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_last,
    input  logic             odd_mode,
    output logic             down_valid,
    output logic [WIDTH-1:0] down_word_xor,
    output logic             down_parity,
    output logic [CNT_W-1:0] down_count,
    output logic             down_overflow
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] word_xor;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf;
    logic             ovf_next;
    logic [WIDTH:0]   par_chain;

    // A first word XORs against zero, so IDLE needs no separate load path.
    assign acc_base = (state == ACCUM) ? acc : '0;

    xor_vec_using_mux #(.WIDTH(WIDTH)) u_word_xor (
        .a(acc_base),
        .b(up_data),
        .y(word_xor)
    );

    // Parity chain seeded with odd_mode, so the final tap already includes the mode.
    assign par_chain[0] = odd_mode;
    for (genvar i = 0; i < WIDTH; i++) begin : g_par
        xor_vec_using_mux #(.WIDTH(1)) u_par (
            .a(par_chain[i]),
            .b(word_xor[i]),
            .y(par_chain[i+1])
        );
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        cnt_next = CNT_W'(1);
        ovf_next = 1'b0;
        if (state == ACCUM) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            ovf_next = ovf | (cnt == CNT_MAX);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            down_valid    <= 1'b0;
            down_word_xor <= '0;
            down_parity   <= 1'b0;
            down_count    <= '0;
            down_overflow <= 1'b0;
        end else begin
            down_valid <= 1'b0;
            if (up_valid) begin
                if (up_last) begin
                    state         <= IDLE;
                    down_valid    <= 1'b1;
                    down_word_xor <= word_xor;
                    down_parity   <= par_chain[WIDTH];
                    down_count    <= cnt_next;
                    down_overflow <= ovf_next;
                end else begin
                    state <= ACCUM;
                    acc   <= word_xor;
                    cnt   <= cnt_next;
                    ovf   <= ovf_next;
                end
            end
        end
    end
endmodule
